// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: digit-serial packed-BCD adder controller.
// One accepted start latches the operands and adds them one decimal digit
// per cycle, least significant digit first. The result, the decimal carry
// out and the error flag are registered and stay stable until the next start.
//
// Optional feature (compile-time macro BCD_DIGIT_CHECK_EN):
//   When defined, an operand digit above 9 aborts the addition early. That
//   digit is not written, err is raised, Cout is cleared and done pulses.
//   When undefined, err is tied low and such digits go through the normal
//   add-and-correct path.
module bcd_serial_add_ctrl #(
    // Digits per operand, legal range 1..8
    parameter int unsigned NDIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] A,
    input  logic [4*NDIG-1:0] B,
    input  logic              Cin,
    output logic [4*NDIG-1:0] S,
    output logic              Cout,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // The digit index is at least 1 bit wide, even when NDIG is 1.
    localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NDIG - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              c_q, c_d;
    logic [4*NDIG-1:0] a_q, a_d;
    logic [4*NDIG-1:0] b_q, b_d;
    logic [4*NDIG-1:0] s_q, s_d;
    logic              cout_q, cout_d;

    // Datapath for the digit currently selected by idx_q
    logic [3:0] a_dig;
    logic [3:0] b_dig;
    logic [4:0] dig_sum;
    logic [4:0] dig_adj;
    logic       dig_gt9;
    logic [3:0] dig_out;
    logic       is_last;

    assign a_dig   = a_q[4*int'(idx_q) +: 4];
    assign b_dig   = b_q[4*int'(idx_q) +: 4];
    assign dig_sum = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, c_q};
    assign dig_gt9 = (dig_sum > 5'd9);
    // Adding 6 skips the six unused codes; the overflow past bit 3 becomes the carry.
    assign dig_adj = dig_sum + 5'd6;
    assign dig_out = dig_gt9 ? dig_adj[3:0] : dig_sum[3:0];
    assign is_last = (idx_q == LastIdx);

`ifdef BCD_DIGIT_CHECK_EN
    logic err_q, err_d;
    logic dig_bad;

    assign dig_bad = (a_dig > 4'd9) || (b_dig > 4'd9);
`endif

    // Next-state and datapath update; every target holds its value unless assigned.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        c_d     = c_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
`ifdef BCD_DIGIT_CHECK_EN
        err_d   = err_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    c_d     = Cin;
                    idx_d   = '0;
                    s_d     = '0;
                    cout_d  = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
                    err_d   = 1'b0;
`endif
                    state_d = StAdd;
                end
            end

            StAdd: begin
`ifdef BCD_DIGIT_CHECK_EN
                if (dig_bad) begin
                    // Keep the digits already written and leave this one untouched.
                    err_d   = 1'b1;
                    cout_d  = 1'b0;
                    state_d = StDone;
                end else
`endif
                begin
                    s_d[4*int'(idx_q) +: 4] = dig_out;
                    c_d = dig_gt9;
                    if (is_last) begin
                        cout_d  = dig_gt9;
                        idx_d   = '0;
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; a synchronous reset takes priority over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            c_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    // Error flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Status outputs are decoded from the state register only.
    assign busy = (state_q == StAdd);
    assign done = (state_q == StDone);
    assign S    = s_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb_bcd_serial_add_ctrl: directed self-checking bench for bcd_serial_add_ctrl (NDIG=4).
// Expected values are hand-computed decimal sums; the bench follows the
// BCD_DIGIT_CHECK_EN macro so that both builds are checked.
module tb_bcd_serial_add_ctrl;

    localparam int unsigned NDIG = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [4*NDIG-1:0] A;
    logic [4*NDIG-1:0] B;
    logic              Cin;
    logic [4*NDIG-1:0] S;
    logic              Cout;
    logic              busy;
    logic              done;
    logic              err;

    int tests_run = 0;
    int tests_failed = 0;

    bcd_serial_add_ctrl #(
        .NDIG(NDIG)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .S    (S),
        .Cout (Cout),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge. Issues one single-cycle start and follows the
    // operation to its done pulse, checking latency, busy length and results.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] exp_s, input logic exp_cout,
                         input logic exp_err, input int exp_done_cyc, input int exp_busy);
        int done_cyc;
        int busy_cnt;
        done_cyc = 0;
        busy_cnt = 0;
        A = a;
        B = b;
        Cin = cin;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = k;
                break;
            end
        end
        check_eq({tag, " done_cycle"}, done_cyc, exp_done_cyc);
        check_eq({tag, " busy_cycles"}, busy_cnt, exp_busy);
        check_eq({tag, " S"}, {16'h0, S}, {16'h0, exp_s});
        check_eq({tag, " Cout"}, {31'h0, Cout}, {31'h0, exp_cout});
        check_eq({tag, " err"}, {31'h0, err}, {31'h0, exp_err});
        // One cycle later: back in idle, results held
        @(negedge clk);
        check_eq({tag, " post_done"}, {30'h0, busy, done}, 32'h0);
        check_eq({tag, " S_hold"}, {16'h0, S}, {16'h0, exp_s});
    endtask

    initial begin
        int done_seen;
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        Cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset outputs", {16'h0, S, Cout, busy, done, err}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle no start", {29'h0, busy, done, err}, 32'h0);

        do_op("1234+5678", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 5, 4);
        do_op("9999+0001", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 5, 4);
        do_op("9999+9999+1", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 5, 4);
        do_op("0000+0000+1", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 5, 4);
        do_op("0456+0789", 16'h0456, 16'h0789, 1'b0, 16'h1245, 1'b0, 1'b0, 5, 4);

        // Results stay put while idle and operand inputs move around
        A = 16'h7777;
        B = 16'h2222;
        repeat (3) @(negedge clk);
        check_eq("idle hold S", {16'h0, S}, 32'h1245);

        // start held high: back-to-back operations with one idle cycle between
        A = 16'h0005;
        B = 16'h0005;
        Cin = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            check_eq($sformatf("b2b busy c%0d", k), {31'h0, busy},
                     {31'h0, ((k >= 1 && k <= 4) || (k >= 7 && k <= 10))});
            check_eq($sformatf("b2b done c%0d", k), {31'h0, done},
                     {31'h0, (k == 5 || k == 11)});
            if (k == 5 || k == 11) begin
                check_eq($sformatf("b2b S c%0d", k), {16'h0, S}, 32'h0010);
                check_eq($sformatf("b2b Cout c%0d", k), {31'h0, Cout}, 32'h0);
            end
            if (k == 2) A = 16'h9999;
            if (k == 3) A = 16'h0005;
            if (k == 11) start = 1'b0;
        end
        @(negedge clk);
        check_eq("b2b stopped", {30'h0, busy, done}, 32'h0);

        // Reset during the second ADD cycle aborts without a done pulse
        A = 16'h1234;
        B = 16'h5678;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort outputs", {16'h0, S, Cout, busy, done, err}, 32'h0);
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check_eq("abort no done", done_seen, 0);
        do_op("after abort", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 5, 4);

        // Digit above 9 in position 1
`ifdef BCD_DIGIT_CHECK_EN
        do_op("bad digit", 16'h00A3, 16'h0001, 1'b0, 16'h0004, 1'b0, 1'b1, 3, 2);
`else
        do_op("bad digit", 16'h00A3, 16'h0001, 1'b0, 16'h0104, 1'b0, 1'b0, 5, 4);
`endif
        // A following valid operation clears err
        do_op("after bad", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 5, 4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
